// File: rtl/lt24_pio_pkg.sv
// lt24_pio_pkg
// Shared constants for the LT24 parallel input port: Avalon word addresses of
// the four registers, the EDGE_TYPE encodings and the edge-selection helper.
package lt24_pio_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_EDGE = 2'd2;
   localparam logic [1:0] ADDR_RAW  = 2'd3;

   localparam int EDGE_RISE = 32'sd0;
   localparam int EDGE_FALL = 32'sd1;
   localparam int EDGE_ANY  = 32'sd2;

   // Keep only the changed bits whose direction matches edge_type.
   // chg marks bits changing this cycle, lvl is their new level.
   function automatic logic [31:0] edge_bits(input int edge_type,
                                             input logic [31:0] chg,
                                             input logic [31:0] lvl);
      logic [31:0] res;
      case (edge_type)
         EDGE_RISE: res = chg & lvl;
         EDGE_FALL: res = chg & ~lvl;
         default:   res = chg;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lt24_pio_debounce.sv
// lt24_pio_debounce
// Sample-based debouncer. On every tick the synchronised input is shifted into
// a DB_SAMPLES-deep history; a bit accepts a new level once every history entry
// agrees. The very first tick that completes the history loads the newest
// sample unconditionally so the output starts from the real pin state.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   tick        one-cycle sample strobe
//   sync        synchronised input bits
//   debounced   registered debounced value
//   db_next     value debounced takes at the next clock edge
//   update      high in the cycle debounced is (re)evaluated with a full history
module lt24_pio_debounce
   import lt24_pio_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int DB_SAMPLES = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] debounced,
   output logic [WIDTH-1:0] db_next,
   output logic             update
);

   // The current sync value is the newest history entry, so only the
   // DB_SAMPLES-1 older samples need storage.
   logic [WIDTH-1:0] hist_r [DB_SAMPLES-1];
   logic [WIDTH-1:0] debounced_r;
   logic [WIDTH-1:0] all_one_s;
   logic [WIDTH-1:0] all_zero_s;
   logic [3:0]       fill_r;
   logic             full_s;
   logic             first_s;

   // Agreement of the full history and the next debounced value.
   always_comb begin
      all_one_s  = sync;
      all_zero_s = ~sync;
      for (int i = 32'sd0; i < DB_SAMPLES - 1; i++) begin
         all_one_s  = all_one_s & hist_r[i];
         all_zero_s = all_zero_s & ~hist_r[i];
      end
      full_s  = (fill_r >= 4'(DB_SAMPLES - 1));
      first_s = (fill_r == 4'(DB_SAMPLES - 1));
      update  = tick & full_s;
      if (update) begin
         if (first_s) begin
            db_next = sync;
         end else begin
            db_next = (debounced_r | all_one_s) & ~all_zero_s;
         end
      end else begin
         db_next = debounced_r;
      end
   end

   // History shift register, fill counter and debounced register.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 32'sd0; i < DB_SAMPLES - 1; i++) begin
            hist_r[i] <= {WIDTH{1'b0}};
         end
         fill_r      <= 4'd0;
         debounced_r <= {WIDTH{1'b0}};
      end else begin
         if (tick) begin
            hist_r[0] <= sync;
            for (int i = 32'sd1; i < DB_SAMPLES - 1; i++) begin
               hist_r[i] <= hist_r[i-1];
            end
            if (fill_r < 4'(DB_SAMPLES)) begin
               fill_r <= fill_r + 4'd1;
            end else begin
               fill_r <= fill_r;
            end
         end else begin
            fill_r <= fill_r;
         end
         debounced_r <= db_next;
      end
   end

   assign debounced = debounced_r;

endmodule

// File: rtl/lt24_pio_in_irq.sv
// lt24_pio_in_irq
// Avalon-MM input port for board switches and keys with synchroniser,
// optional debouncer, per-bit edge capture (write-1-to-clear), interrupt mask
// and level interrupt. Read data is registered every cycle from the address.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   address             word address (0 DATA, 1 MASK, 2 EDGE, 3 RAW)
//   read, write         Avalon strobes (read data does not depend on read)
//   writedata           write data, WIDTH LSBs used
//   readdata            registered read data, one cycle latency
//   in_port             asynchronous pin inputs
//   irq                 registered |(EDGE & MASK)
module lt24_pio_in_irq
   import lt24_pio_pkg::*;
#(
   parameter int WIDTH       = 10,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE_EN = 1,
   parameter int TICK_DIV    = 50000,
   parameter int DB_SAMPLES  = 4,
   parameter int EDGE_TYPE   = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int TW = $clog2(TICK_DIV);

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] sync_s;
   logic [WIDTH-1:0] deb_cur_s;
   logic [WIDTH-1:0] deb_next_s;
   logic [WIDTH-1:0] chg_s;
   logic [WIDTH-1:0] set_s;
   logic [WIDTH-1:0] edge_clr_s;
   logic [WIDTH-1:0] edge_r;
   logic [WIDTH-1:0] mask_r;
   logic [31:0]      set32_s;
   logic [31:0]      readdata_r;
   logic [TW-1:0]    tick_cnt_r;
   logic             tick_s;
   logic             update_s;
   logic             prime_r;
   logic             irq_r;
   logic             unused_s;

   // Input synchroniser chain; the last stage is the RAW value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 32'sd0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         sync_r[0] <= in_port;
         for (int i = 32'sd1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   assign sync_s = sync_r[SYNC_STAGES-1];
   assign tick_s = (tick_cnt_r == TW'(TICK_DIV - 1));

   // Sample tick divider, wraps at TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_r <= {TW{1'b0}};
      end else if (tick_s) begin
         tick_cnt_r <= {TW{1'b0}};
      end else begin
         tick_cnt_r <= tick_cnt_r + TW'(1);
      end
   end

   generate
      if (DEBOUNCE_EN != 0) begin : g_db
         lt24_pio_debounce #(
            .WIDTH      (WIDTH),
            .DB_SAMPLES (DB_SAMPLES)
         ) u_db (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick_s),
            .sync       (sync_s),
            .debounced  (deb_cur_s),
            .db_next    (deb_next_s),
            .update     (update_s)
         );
      end else begin : g_bypass
         // Debounced is the sync stage itself; its next value is the stage before it.
         assign deb_cur_s  = sync_s;
         assign deb_next_s = sync_r[SYNC_STAGES-2];
         assign update_s   = 1'b1;
      end
   endgenerate

   // Edge set/clear terms; edges only count once the first load has happened.
   always_comb begin
      if (prime_r && update_s) begin
         chg_s = deb_next_s ^ deb_cur_s;
      end else begin
         chg_s = {WIDTH{1'b0}};
      end
      set32_s = edge_bits(EDGE_TYPE, 32'(chg_s), 32'(deb_next_s));
      set_s   = set32_s[WIDTH-1:0];
      if (write && (address == ADDR_EDGE)) begin
         edge_clr_s = writedata[WIDTH-1:0];
      end else begin
         edge_clr_s = {WIDTH{1'b0}};
      end
   end

   // Prime flag, edge capture (set beats clear), mask and irq registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         prime_r <= 1'b0;
         edge_r  <= {WIDTH{1'b0}};
         mask_r  <= {WIDTH{1'b0}};
         irq_r   <= 1'b0;
      end else begin
         prime_r <= prime_r | update_s;
         edge_r  <= (edge_r & ~edge_clr_s) | set_s;
         if (write && (address == ADDR_MASK)) begin
            mask_r <= writedata[WIDTH-1:0];
         end else begin
            mask_r <= mask_r;
         end
         irq_r <= |(edge_r & mask_r);
      end
   end

   // Registered read mux, updated every cycle regardless of read.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_r <= 32'd0;
      end else begin
         case (address)
            ADDR_DATA: readdata_r <= 32'(deb_cur_s);
            ADDR_MASK: readdata_r <= 32'(mask_r);
            ADDR_EDGE: readdata_r <= 32'(edge_r);
            ADDR_RAW:  readdata_r <= 32'(sync_s);
            default:   readdata_r <= 32'd0;
         endcase
      end
   end

   assign readdata = readdata_r;
   assign irq      = irq_r;
   assign unused_s = &{1'b0, read, writedata, set32_s};

endmodule

// File: tb/tb_lt24_pio_in_irq.sv
// Directed bench for lt24_pio_in_irq with WIDTH=10, TICK_DIV=4, DB_SAMPLES=3,
// EDGE_TYPE=any. Tick samples land on edges where cyc%4==0 and take the pin
// value from two edges earlier; the phase-sensitive tests rely on that.
module tb_lt24_pio_in_irq;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  in_port;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   lt24_pio_in_irq #(
      .WIDTH       (10),
      .SYNC_STAGES (2),
      .DEBOUNCE_EN (1),
      .TICK_DIV    (4),
      .DB_SAMPLES  (3),
      .EDGE_TYPE   (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .irq       (irq)
   );

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      read    = 1'b1;
      @(negedge clk);
      d    = readdata;
      read = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address   = a;
      writedata = d;
      write     = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic wait_phase(input int r);
      bit found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         @(negedge clk);
         if (cyc % 4 == r) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL wait_phase: phase %0d not reached, required within 8 cycles", r);
      end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      int k;
      bit got;
      in_port = 10'h155; reset = 1'b1; read = 1'b0; write = 1'b0;
      address = 2'd0; writedata = 32'd0;
      repeat (3) @(negedge clk);
      n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata: got %h required 0", readdata); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b required 0", irq); end
      reset = 1'b0;
      got = 1'b0;
      k = 0;
      while (k < 20 && !got) begin
         @(negedge clk);
         k++;
         if (readdata === 32'h155) got = 1'b1;
      end
      n_cmp++; if (!got || k > 14) begin n_err++; $display("FAIL prime_data: got %h after %0d cycles required 155 within 14", readdata, k); end
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL prime_edge: got %h required 0", d); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL prime_irq: got %b required 0", irq); end
   endtask

   task automatic test_edge_irq;
      logic [31:0] d;
      in_port[0] = 1'b0;
      repeat (20) @(negedge clk);
      bus_write(2'd2, 32'h3FF);
      bus_write(2'd1, 32'h001);
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL edge_cleared: got %h required 0", d); end
      wait_phase(0);
      in_port[0] = 1'b1;
      repeat (12) @(negedge clk);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b required 0", irq); end
      @(negedge clk);
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b required 1", irq); end
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'h001) begin n_err++; $display("FAIL edge_bit0: got %h required 001", d); end
      bus_read(2'd0, d);
      n_cmp++; if (d !== 32'h155) begin n_err++; $display("FAIL data_bit0: got %h required 155", d); end
      bus_write(2'd2, 32'h001);
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_w1c_lag: got %b required 1", irq); end
      @(negedge clk);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c: got %b required 0", irq); end
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL edge_w1c: got %h required 0", d); end
   endtask

   task automatic test_glitch;
      logic [31:0] d;
      bit seen = 1'b0;
      @(negedge clk);
      address = 2'd3;
      wait_phase(2);
      in_port[3] = 1'b1;
      repeat (3) begin @(negedge clk); seen = seen | readdata[3]; end
      in_port[3] = 1'b0;
      repeat (4) begin @(negedge clk); seen = seen | readdata[3]; end
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL raw_pulse: got %b required 1", seen); end
      repeat (16) @(negedge clk);
      bus_read(2'd0, d);
      n_cmp++; if (d !== 32'h155) begin n_err++; $display("FAIL glitch_data: got %h required 155", d); end
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL glitch_edge: got %h required 0", d); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      wait_phase(0);
      in_port[2] = 1'b0;
      repeat (11) @(negedge clk);
      address   = 2'd2;
      writedata = 32'h004;
      write     = 1'b1;
      @(negedge clk);
      write = 1'b0;
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'h004) begin n_err++; $display("FAIL set_beats_clear: got %h required 004", d); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked_bit2: got %b required 0", irq); end
      bus_write(2'd2, 32'h004);
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL edge_bit2_w1c: got %h required 0", d); end
      bus_read(2'd0, d);
      n_cmp++; if (d !== 32'h151) begin n_err++; $display("FAIL data_bit2: got %h required 151", d); end
   endtask

   task automatic test_mask;
      logic [31:0] d;
      bus_write(2'd1, 32'h000);
      in_port[5] = 1'b1;
      repeat (20) @(negedge clk);
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'h020) begin n_err++; $display("FAIL edge_bit5: got %h required 020", d); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_mask0: got %b required 0", irq); end
      bus_write(2'd1, 32'h020);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_mask_lag: got %b required 0", irq); end
      @(negedge clk);
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_unmask: got %b required 1", irq); end
      bus_read(2'd1, d);
      n_cmp++; if (d !== 32'h020) begin n_err++; $display("FAIL mask_read: got %h required 020", d); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      in_port = 10'h28E;
      repeat (20) @(negedge clk);
      bus_write(2'd1, 32'hFFFF_FFFF);
      bus_read(2'd1, d);
      n_cmp++; if (d !== 32'h3FF) begin n_err++; $display("FAIL mask_width: got %h required 3ff", d); end
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'h3FF) begin n_err++; $display("FAIL edge_all: got %h required 3ff", d); end
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_all: got %b required 1", irq); end
      @(negedge clk);
      address = 2'd1;
      reset   = 1'b1;
      @(negedge clk);
      n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL midreset_readdata: got %h required 0", readdata); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq: got %b required 0", irq); end
      reset = 1'b0;
      bus_read(2'd1, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL midreset_mask: got %h required 0", d); end
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL midreset_edge: got %h required 0", d); end
      bus_read(2'd0, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL unprimed_data: got %h required 0", d); end
      repeat (20) @(negedge clk);
      bus_read(2'd0, d);
      n_cmp++; if (d !== 32'h28E) begin n_err++; $display("FAIL reprimed_data: got %h required 28e", d); end
      bus_read(2'd2, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reprimed_edge: got %h required 0", d); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reprimed_irq: got %b required 0", irq); end
   endtask

   initial begin
      test_reset();
      test_edge_irq();
      test_glitch();
      test_back_to_back();
      test_mask();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
